pong_vga_renderer: RTL and testbench

Parametrised successor to the pong VGA pixel path. It integrates its own sync counters, so no separate sync generator is needed. Game state is latched once per frame at the start of vertical blanking, which prevents tearing. Colour, hsync, vsync and a frame strobe are emitted through one aligned register stage. The block sits between the game logic (ball/paddle state) and the board's VGA pins, clocked at the pixel clock (31.5 MHz for the defaults).

---
 rtl/pong_vga_renderer.sv | 119 +++++++++++
 tb/tb_pong_vga_renderer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_vga_renderer.sv
// Pong VGA pixel path with built-in sync counters, per-frame shadowed game state
// and one aligned output register stage for colour, syncs and frame strobe.
module pong_vga_renderer #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 24,
   parameter int H_SYNC     = 40,
   parameter int H_BP       = 128,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 9,
   parameter int V_SYNC     = 3,
   parameter int V_BP       = 28,
   parameter int COORD_W    = 4,
   parameter int CELL_SHIFT = 4,
   parameter int BG_FRAMES  = 64,
   parameter int MIRROR     = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [COORD_W-1:0]      ball_x,
   input  logic [COORD_W-1:0]      ball_y,
   input  logic [(2**COORD_W)-1:0] lpaddle,
   input  logic [(2**COORD_W)-1:0] rpaddle,
   output logic                    hsync,
   output logic                    vsync,
   output logic [5:0]              rrggbb,
   output logic                    frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PFB     = COORD_W + CELL_SHIFT;
   localparam int HW      = ($clog2(H_TOTAL + 1) > PFB) ? $clog2(H_TOTAL + 1) : PFB;
   localparam int VW      = ($clog2(V_TOTAL + 1) > PFB) ? $clog2(V_TOTAL + 1) : PFB;
   localparam int GRID    = 2 ** COORD_W;
   localparam int FCW     = (BG_FRAMES > 1) ? $clog2(BG_FRAMES) : 1;

   localparam logic [HW-1:0]      H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]      H_ACT   = HW'(H_ACTIVE);
   localparam logic [HW-1:0]      HS_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]      HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]      V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]      V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0]      VS_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]      VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [FCW-1:0]     FC_LAST = FCW'(BG_FRAMES - 1);
   localparam logic [COORD_W-1:0] LCOL    = (MIRROR != 0) ? '1 : '0;
   localparam logic [COORD_W-1:0] RCOL    = (MIRROR != 0) ? '0 : '1;

   logic [HW-1:0]      h;
   logic [VW-1:0]      v;
   logic [COORD_W-1:0] sb_x, sb_y;
   logic [GRID-1:0]    sl, sr;
   logic [FCW-1:0]     fc;
   logic [2:0]         bg;

   logic               latch, active, in_pf, hit, hs_n, vs_n;
   logic [COORD_W-1:0] cx, cy;
   logic [5:0]         pix_rgb;

   always_comb begin
      latch   = (h == '0) && (v == V_ACT);
      active  = (h < H_ACT) && (v < V_ACT);
      in_pf   = ((h >> PFB) == '0) && ((v >> PFB) == '0);
      cx      = h[CELL_SHIFT +: COORD_W];
      cy      = v[CELL_SHIFT +: COORD_W];
      hit     = ((cx == sb_x) && (cy == sb_y)) ||
                ((cx == LCOL) && sl[cy]) ||
                ((cx == RCOL) && sr[cy]);
      hs_n    = !((h >= HS_BEG) && (h < HS_END));
      vs_n    = !((v >= VS_BEG) && (v < VS_END));
      pix_rgb = '0;
      if (active) begin
         if (in_pf && hit) pix_rgb = '1;
         else              pix_rgb = {bg[2], 1'b0, bg[1], 1'b0, bg[0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h           <= '0;
         v           <= '0;
         sb_x        <= '0;
         sb_y        <= '0;
         sl          <= '0;
         sr          <= '0;
         fc          <= '0;
         bg          <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         rrggbb      <= '0;
         frame_start <= 1'b0;
      end else begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
         // Latch happens in blanking, so the new state and colour start on line 0.
         if (latch) begin
            sb_x <= ball_x;
            sb_y <= ball_y;
            sl   <= lpaddle;
            sr   <= rpaddle;
            if (fc == FC_LAST) begin
               fc <= '0;
               bg <= bg + 1'b1;
            end else begin
               fc <= fc + 1'b1;
            end
         end
         hsync       <= hs_n;
         vsync       <= vs_n;
         rrggbb      <= pix_rgb;
         frame_start <= latch;
      end
   end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed bench for pong_vga_renderer on a shrunken timing (50x42 total, 8x8 grid of 4 px cells);
// instance a uses MIRROR=1/BG_FRAMES=2, instance b uses MIRROR=0/BG_FRAMES=1.
module tb_pong_vga_renderer;

   localparam int HA = 40, HFP = 2, HS = 4, HBP = 4;
   localparam int VA = 36, VFP = 2, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;  // 50
   localparam int VT = VA + VFP + VS + VBP;  // 42
   localparam int FRAME = HT * VT;           // 2100

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] ball_x = 3'd3, ball_y = 3'd5;
   logic [7:0] lpaddle = '0, rpaddle = '0;
   logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
   logic [5:0] rr_a, rr_b;

   int tests_run = 0, tests_failed = 0;

   // Bench-side view of which counter position the outputs currently show.
   int pix = -1, oh = 0, ov = 0;
   logic [2:0] m_bx = '0, m_by = '0, m_bg_a = '0, m_bg_b = '0;
   logic [7:0] m_l = '0, m_r = '0;
   int m_fc_a = 0;
   int err_pix = 0, err_sync = 0, err_fs = 0, err_rst = 0;
   int bad_h = 0, bad_v = 0;
   logic [5:0] bad_got = '0, bad_exp = '0;

   pong_vga_renderer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .COORD_W(3), .CELL_SHIFT(2), .BG_FRAMES(2), .MIRROR(1)
   ) dut_a (
      .clk(clk), .reset(reset), .ball_x(ball_x), .ball_y(ball_y),
      .lpaddle(lpaddle), .rpaddle(rpaddle),
      .hsync(hs_a), .vsync(vs_a), .rrggbb(rr_a), .frame_start(fs_a)
   );

   pong_vga_renderer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .COORD_W(3), .CELL_SHIFT(2), .BG_FRAMES(1), .MIRROR(0)
   ) dut_b (
      .clk(clk), .reset(reset), .ball_x(ball_x), .ball_y(ball_y),
      .lpaddle(lpaddle), .rpaddle(rpaddle),
      .hsync(hs_b), .vsync(vs_b), .rrggbb(rr_b), .frame_start(fs_b)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] bgcol(input logic [2:0] b);
      return {b[2], 1'b0, b[1], 1'b0, b[0], 1'b0};
   endfunction

   function automatic logic [5:0] exp_rgb(input int h, input int v, input logic [2:0] bx,
                                          input logic [2:0] by, input logic [7:0] l,
                                          input logic [7:0] r, input logic [2:0] b, input bit mir);
      int cx, cy, lc, rc;
      if (h >= HA || v >= VA) return 6'b000000;
      if (h < 32 && v < 32) begin
         cx = h / 4;
         cy = v / 4;
         lc = mir ? 7 : 0;
         rc = mir ? 0 : 7;
         if ((cx == int'(bx) && cy == int'(by)) || (cx == lc && l[cy]) || (cx == rc && r[cy]))
            return 6'b111111;
      end
      return bgcol(b);
   endfunction

   task automatic note_pix(input logic [5:0] got, input logic [5:0] exp);
      if (got !== exp) begin
         if (err_pix == 0) begin
            bad_h = oh; bad_v = ov; bad_got = got; bad_exp = exp;
         end
         err_pix++;
      end
   endtask

   // One clock: advance the position model, check every output, mirror the latch.
   task automatic step();
      logic eh, ev, ef;
      @(posedge clk);
      #1;
      if (reset) begin
         pix = -1;
         m_bx = '0; m_by = '0; m_l = '0; m_r = '0;
         m_fc_a = 0; m_bg_a = '0; m_bg_b = '0;
         if (hs_a !== 1'b1 || vs_a !== 1'b1 || rr_a !== 6'd0 || fs_a !== 1'b0 ||
             hs_b !== 1'b1 || vs_b !== 1'b1 || rr_b !== 6'd0 || fs_b !== 1'b0)
            err_rst++;
      end else begin
         pix++;
         oh = pix % HT;
         ov = (pix / HT) % VT;
         eh = !(oh >= HA + HFP && oh < HA + HFP + HS);
         ev = !(ov >= VA + VFP && ov < VA + VFP + VS);
         ef = (oh == 0 && ov == VA);
         if (hs_a !== eh || vs_a !== ev || hs_b !== eh || vs_b !== ev) err_sync++;
         if (fs_a !== ef || fs_b !== ef) err_fs++;
         note_pix(rr_a, exp_rgb(oh, ov, m_bx, m_by, m_l, m_r, m_bg_a, 1'b1));
         note_pix(rr_b, exp_rgb(oh, ov, m_bx, m_by, m_l, m_r, m_bg_b, 1'b0));
         if (ef) begin
            m_bx = ball_x; m_by = ball_y; m_l = lpaddle; m_r = rpaddle;
            if (m_fc_a == 1) begin m_fc_a = 0; m_bg_a = m_bg_a + 3'd1; end
            else m_fc_a++;
            m_bg_b = m_bg_b + 3'd1;
         end
      end
   endtask

   task automatic wait_pixel(input int h, input int v);
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if (!reset && oh == h && ov == v) return;
      end
      tests_run++;
      tests_failed++;
      $display("FAIL wait_pixel timeout: pos (%0d,%0d) required (%0d,%0d)", oh, ov, h, v);
   endtask

   task automatic clear_errs();
      err_pix = 0; err_sync = 0; err_fs = 0; err_rst = 0;
   endtask

   task automatic check_errs(input string name);
      tests_run++;
      if (err_pix !== 0) begin
         tests_failed++;
         $display("FAIL %s pixels: %0d wrong, first at (%0d,%0d) got %b required %b",
                  name, err_pix, bad_h, bad_v, bad_got, bad_exp);
      end
      tests_run++;
      if (err_sync !== 0 || err_fs !== 0 || err_rst !== 0) begin
         tests_failed++;
         $display("FAIL %s timing: sync errs %0d fs errs %0d reset errs %0d required 0",
                  name, err_sync, err_fs, err_rst);
      end
   endtask

   task automatic test_reset();
      clear_errs();
      reset = 1'b1;
      repeat (3) step();
      tests_run++;
      if (hs_a !== 1'b1 || vs_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_sync: hsync %b vsync %b required 1 1", hs_a, vs_a);
      end
      tests_run++;
      if (rr_a !== 6'b000000 || rr_b !== 6'b000000) begin
         tests_failed++;
         $display("FAIL reset_rgb: a %b b %b required 000000", rr_a, rr_b);
      end
      tests_run++;
      if (fs_a !== 1'b0 || fs_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_fs: a %b b %b required 0", fs_a, fs_b);
      end
      reset = 1'b0;
   endtask

   task automatic test_first_frame();
      int n = -1;
      clear_errs();
      for (int i = 1; i <= FRAME + 200; i++) begin
         step();
         if (fs_a === 1'b1) begin n = i; break; end
      end
      tests_run++;
      if (n !== VA * HT + 1) begin
         tests_failed++;
         $display("FAIL first_frame_start latency: got %0d required %0d", n, VA * HT + 1);
      end
      check_errs("first_frame");
   endtask

   task automatic test_ball();
      clear_errs();
      wait_pixel(12, 20);
      tests_run++;
      if (rr_a !== 6'b111111 || rr_b !== 6'b111111) begin
         tests_failed++;
         $display("FAIL ball_inside: a %b b %b required 111111", rr_a, rr_b);
      end
      wait_pixel(16, 20);
      tests_run++;
      if (rr_a !== 6'b000000 || rr_b !== 6'b000010) begin
         tests_failed++;
         $display("FAIL ball_right_edge: a %b b %b required 000000 000010", rr_a, rr_b);
      end
      wait_pixel(15, 24);
      tests_run++;
      if (rr_b !== 6'b000010) begin
         tests_failed++;
         $display("FAIL ball_below: got %b required 000010", rr_b);
      end
      wait_pixel(0, VA);
      check_errs("ball");
   endtask

   task automatic test_tear_free();
      clear_errs();
      wait_pixel(0, 10);
      ball_x = 3'd6;
      wait_pixel(12, 22);
      tests_run++;
      if (rr_a !== 6'b111111) begin
         tests_failed++;
         $display("FAIL tear_old_column: got %b required 111111", rr_a);
      end
      wait_pixel(24, 22);
      tests_run++;
      if (rr_a !== bgcol(m_bg_a)) begin
         tests_failed++;
         $display("FAIL tear_new_column_early: got %b required %b", rr_a, bgcol(m_bg_a));
      end
      wait_pixel(0, VA);
      wait_pixel(12, 22);
      tests_run++;
      if (rr_a !== bgcol(m_bg_a)) begin
         tests_failed++;
         $display("FAIL tear_old_column_next: got %b required %b", rr_a, bgcol(m_bg_a));
      end
      wait_pixel(24, 22);
      tests_run++;
      if (rr_a !== 6'b111111) begin
         tests_failed++;
         $display("FAIL tear_new_column_next: got %b required 111111", rr_a);
      end
      check_errs("tear_free");
   endtask

   task automatic test_sync();
      int hl = 0, vl = 0, run = 0, max_run = 0;
      clear_errs();
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (hs_a === 1'b0) begin hl++; run++; if (run > max_run) max_run = run; end
         else run = 0;
         if (vs_a === 1'b0) vl++;
      end
      tests_run++;
      if (hl !== VT * HS || max_run !== HS) begin
         tests_failed++;
         $display("FAIL hsync_width: low %0d run %0d required %0d run %0d", hl, max_run, VT * HS, HS);
      end
      tests_run++;
      if (vl !== VS * HT) begin
         tests_failed++;
         $display("FAIL vsync_width: low %0d required %0d", vl, VS * HT);
      end
      check_errs("sync");
   endtask

   task automatic test_paddles();
      clear_errs();
      ball_x = 3'd4; ball_y = 3'd7;
      lpaddle = 8'b0011_1100;
      rpaddle = 8'b0000_0011;
      wait_pixel(0, VA);
      wait_pixel(0, 0);
      tests_run++;
      if (rr_a !== 6'b111111 || rr_b !== bgcol(m_bg_b)) begin
         tests_failed++;
         $display("FAIL paddle_col0_row0: a %b b %b required 111111 %b", rr_a, rr_b, bgcol(m_bg_b));
      end
      wait_pixel(28, 4);
      tests_run++;
      if (rr_a !== bgcol(m_bg_a) || rr_b !== 6'b111111) begin
         tests_failed++;
         $display("FAIL paddle_col7_row1: a %b b %b required %b 111111", rr_a, rr_b, bgcol(m_bg_a));
      end
      wait_pixel(28, 8);
      tests_run++;
      if (rr_a !== 6'b111111 || rr_b !== bgcol(m_bg_b)) begin
         tests_failed++;
         $display("FAIL paddle_col7_row2: a %b b %b required 111111 %b", rr_a, rr_b, bgcol(m_bg_b));
      end
      wait_pixel(0, 12);
      tests_run++;
      if (rr_a !== bgcol(m_bg_a) || rr_b !== 6'b111111) begin
         tests_failed++;
         $display("FAIL paddle_col0_row3: a %b b %b required %b 111111", rr_a, rr_b, bgcol(m_bg_a));
      end
      wait_pixel(16, 28);
      tests_run++;
      if (rr_a !== 6'b111111 || rr_b !== 6'b111111) begin
         tests_failed++;
         $display("FAIL paddle_ball: a %b b %b required 111111", rr_a, rr_b);
      end
      wait_pixel(0, VA);
      check_errs("paddles");
   endtask

   task automatic test_background();
      logic [5:0] exp_a [5] = '{6'b000000, 6'b000000, 6'b000010, 6'b000010, 6'b001000};
      logic [5:0] exp_b [5] = '{6'b000000, 6'b000010, 6'b001000, 6'b001010, 6'b100000};
      clear_errs();
      wait_pixel(0, 20);
      reset = 1'b1;
      step();
      tests_run++;
      if (hs_a !== 1'b1 || vs_a !== 1'b1 || rr_a !== 6'b000000 || fs_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL midframe_reset_outputs: hs %b vs %b rgb %b fs %b required 1 1 000000 0",
                  hs_a, vs_a, rr_a, fs_a);
      end
      reset = 1'b0;
      step();
      tests_run++;
      if (rr_a !== 6'b111111 || hs_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL midframe_reset_restart: rgb %b hs %b required 111111 1", rr_a, hs_a);
      end
      for (int f = 0; f < 5; f++) begin
         wait_pixel(36, 0);
         tests_run++;
         if (rr_a !== exp_a[f] || rr_b !== exp_b[f]) begin
            tests_failed++;
            $display("FAIL bg_frame%0d_top: a %b b %b required %b %b", f, rr_a, rr_b, exp_a[f], exp_b[f]);
         end
         wait_pixel(36, VA - 1);
         tests_run++;
         if (rr_a !== exp_a[f] || rr_b !== exp_b[f]) begin
            tests_failed++;
            $display("FAIL bg_frame%0d_bottom: a %b b %b required %b %b", f, rr_a, rr_b, exp_a[f], exp_b[f]);
         end
      end
      check_errs("background");
   endtask

   task automatic test_reset_vs_latch();
      clear_errs();
      wait_pixel(HT - 1, VA - 1);
      reset = 1'b1;
      step();
      tests_run++;
      if (fs_a !== 1'b0 || fs_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_beats_latch: fs a %b b %b required 0", fs_a, fs_b);
      end
      reset = 1'b0;
      repeat (VA * HT + 5) step();
      check_errs("reset_vs_latch");
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_ball();
      test_tear_free();
      test_sync();
      test_paddles();
      test_background();
      test_reset_vs_latch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
